// File: rtl/sub_unsigned_8bit.sv
// Unsigned WIDTH-bit subtractor: combinational difference/borrow from a ripple
// full-subtractor chain, plus a registered copy with valid, zero and sticky borrow.

module sub_unsigned_8bit_fs (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

module sub_unsigned_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    input  logic             sticky_clr,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic [WIDTH-1:0] result_q,
    output logic             borrow_q,
    output logic             zero_q,
    output logic             out_valid,
    output logic             borrow_sticky
);
    logic [WIDTH:0]   w_bchain;
    logic [WIDTH-1:0] w_diff;

    logic [WIDTH-1:0] r_result;
    logic             r_borrow;
    logic             r_zero;
    logic             r_valid;
    logic             r_sticky;

    // Borrow-in of the LSB cell is 0; the MSB borrow-out is the subtractor borrow.
    assign w_bchain[0] = 1'b0;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        sub_unsigned_8bit_fs u_fs (
            .i_a    (A[g]),
            .i_b    (B[g]),
            .i_bin  (w_bchain[g]),
            .o_d    (w_diff[g]),
            .o_bout (w_bchain[g+1])
        );
    end

    assign result = w_diff;
    assign borrow = w_bchain[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b1;
            r_valid  <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_diff;
                r_borrow <= w_bchain[WIDTH];
                r_zero   <= (w_diff == '0);
            end
            // Clear wins over a borrow captured in the same cycle.
            if (sticky_clr)
                r_sticky <= 1'b0;
            else if (in_valid && w_bchain[WIDTH])
                r_sticky <= 1'b1;
        end
    end

    assign result_q      = r_result;
    assign borrow_q      = r_borrow;
    assign zero_q        = r_zero;
    assign out_valid     = r_valid;
    assign borrow_sticky = r_sticky;
endmodule

// File: tb/tb_sub_unsigned_8bit.sv
// Directed and table-driven checks of the subtractor's combinational and registered paths.

module tb_sub_unsigned_8bit;
    logic       clk;
    logic       rst_n;
    logic [7:0] A, B;
    logic       in_valid, sticky_clr;
    logic [7:0] result, result_q;
    logic       borrow, borrow_q, zero_q, out_valid, borrow_sticky;

    int errs   = 0;
    int checks = 0;

    sub_unsigned_8bit #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .A             (A),
        .B             (B),
        .in_valid      (in_valid),
        .sticky_clr    (sticky_clr),
        .result        (result),
        .borrow        (borrow),
        .result_q      (result_q),
        .borrow_q      (borrow_q),
        .zero_q        (zero_q),
        .out_valid     (out_valid),
        .borrow_sticky (borrow_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hand-computed directed vectors: A, B, result, borrow
    logic [7:0] va[10] = '{8'd100, 8'd200, 8'd50,  8'd0,   8'd255, 8'd0,   8'd1, 8'd255, 8'd0,   8'd128};
    logic [7:0] vb[10] = '{8'd100, 8'd50,  8'd200, 8'd0,   8'd255, 8'd1,   8'd0, 8'd0,   8'd255, 8'd129};
    logic [7:0] vr[10] = '{8'd0,   8'd150, 8'd106, 8'd0,   8'd0,   8'd255, 8'd1, 8'd255, 8'd1,   8'd255};
    logic       vbo[10] = '{1'b0,  1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0, 1'b0,   1'b1,   1'b1};

    task automatic comb(input string tag, input int a, input int b);
        int d;
        A = 8'(a);
        B = 8'(b);
        #1;
        d = (a - b) & 255;
        chk({tag, "_res"}, 32'(result), 32'(d));
        chk({tag, "_bor"}, 32'(borrow), 32'(a < b));
    endtask

    task automatic reg_chk(input string tag, input int rq, input int bq, input int zq,
                           input int ov, input int st);
        chk({tag, "_result_q"}, 32'(result_q), 32'(rq));
        chk({tag, "_borrow_q"}, 32'(borrow_q), 32'(bq));
        chk({tag, "_zero_q"}, 32'(zero_q), 32'(zq));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, "_sticky"}, 32'(borrow_sticky), 32'(st));
    endtask

    task automatic step(input int a, input int b, input logic v, input logic clr);
        @(negedge clk);
        A = 8'(a); B = 8'(b); in_valid = v; sticky_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sticky_clr = 1'b0; A = '0; B = '0;
        #12;
        reg_chk("reset", 0, 0, 1, 0, 0);
        comb("comb_in_reset", 50, 200);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            A = va[i]; B = vb[i];
            #1;
            chk($sformatf("dir%0d_res", i), 32'(result), 32'(vr[i]));
            chk($sformatf("dir%0d_bor", i), 32'(borrow), 32'(vbo[i]));
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                comb("exh", a, b);

        for (int i = 0; i < 1000; i++)
            comb("rnd", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

        // Registered path
        step(0, 1, 1'b1, 1'b0);
        reg_chk("cap_0m1", 255, 1, 0, 1, 1);
        step(100, 100, 1'b0, 1'b0);
        reg_chk("hold", 255, 1, 0, 0, 1);
        step(100, 100, 1'b1, 1'b0);
        reg_chk("cap_eq", 0, 0, 1, 1, 1);
        step(0, 255, 1'b1, 1'b1);
        reg_chk("clr_prio", 1, 1, 0, 1, 0);
        step(200, 50, 1'b1, 1'b0);
        reg_chk("cap_200m50", 150, 0, 0, 1, 0);
        step(5, 6, 1'b0, 1'b0);
        reg_chk("no_cap_borrow", 150, 0, 0, 0, 0);
        step(5, 6, 1'b1, 1'b0);
        reg_chk("cap_5m6", 255, 1, 0, 1, 1);
        step(9, 3, 1'b0, 1'b1);
        reg_chk("clr_idle", 255, 1, 0, 0, 0);

        // Asynchronous reset mid-stream
        step(7, 9, 1'b1, 1'b0);
        reg_chk("pre_rst", 254, 1, 0, 1, 1);
        @(negedge clk);
        A = 8'd0; B = 8'd1; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        reg_chk("async_rst", 0, 0, 1, 0, 0);
        chk("async_rst_comb_res", 32'(result), 32'd255);
        chk("async_rst_comb_bor", 32'(borrow), 32'd1);
        @(posedge clk);
        #1;
        reg_chk("rst_held", 0, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1; A = 8'd3; B = 8'd1;
        @(posedge clk);
        #1;
        reg_chk("first_cap", 2, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
